// File: rtl/trace_capture_if.sv
// Readout stream of the trace buffer: one captured sample per beat over valid/ready.
// The buffer drives through master; the sink (e.g. a UART TX path) connects to slave.
interface trace_capture_if #(
    parameter int DATA_W = 128
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// On-chip trace buffer: samples probe channels into a circular RAM, triggers on a
// programmable match, keeps a DEPTH-sample window around it and streams it out oldest first.
module trace_capture #(
    parameter int  NUM_PROBES  = 4,
    parameter int  PROBE_WIDTH = 32,
    parameter int  DEPTH       = 256,
    parameter int  PRE_TRIGGER = 64,
    localparam int CH_W        = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PROBES*PROBE_WIDTH-1:0] probe_data,
    input  logic                              probe_valid,
    input  logic                              arm,
    input  logic [CH_W-1:0]                   trig_channel,
    input  logic [PROBE_WIDTH-1:0]            trig_value,
    input  logic [PROBE_WIDTH-1:0]            trig_mask,
    input  logic [1:0]                        trig_mode,
    output logic                              busy,
    output logic                              triggered,
    output logic                              done,
    trace_capture_if.master                   rd
);
    localparam int              SW        = NUM_PROBES * PROBE_WIDTH;
    localparam int              AW        = $clog2(DEPTH);
    localparam int              POST_N    = DEPTH - PRE_TRIGGER - 1;
    localparam logic [AW-1:0]   PRE_OFS   = AW'(PRE_TRIGGER);
    localparam logic [AW-1:0]   POST_INIT = AW'(POST_N);
    localparam logic [AW:0]     BEATS     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     LAST_CNT  = (AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_READOUT} state_t;
    typedef enum logic [1:0] {M_EQ, M_NEQ, M_CHANGE, M_IMM} mode_t;

    state_t state, state_d;

    logic [SW-1:0]          mem [DEPTH];
    logic [SW-1:0]          ram_q;
    logic [AW-1:0]          wr_ptr, wr_addr, trig_ptr, trig_next, rd_ptr, fill, post;
    logic [AW:0]            issue_cnt;
    logic [CH_W-1:0]        chan_q;
    logic [PROBE_WIDTH-1:0] value_q, mask_q, cur_ch, prev_ch;
    mode_t                  mode_q;
    logic [SW-1:0]          prev_q;
    logic                   prev_valid, match;
    logic                   start, sample, hit, entering, end_beat, out_load, issue;
    logic                   s1_valid, s1_last;

    // Arm restarts any capture in progress but never disturbs a readout.
    assign start    = arm && (state != S_READOUT);
    assign sample   = probe_valid && (start || state inside {S_PRE, S_ARMED, S_POST});
    assign wr_addr  = start ? '0 : wr_ptr;
    assign busy     = (state != S_IDLE);
    assign end_beat = rd.rd_valid && rd.rd_ready && rd.rd_last;

    // Out-of-range channel numbers fall back to channel 0.
    always_comb begin
        cur_ch  = probe_data[PROBE_WIDTH-1:0];
        prev_ch = prev_q[PROBE_WIDTH-1:0];
        for (int k = 1; k < NUM_PROBES; k++) begin
            if (int'(chan_q) == k) begin
                cur_ch  = probe_data[k*PROBE_WIDTH +: PROBE_WIDTH];
                prev_ch = prev_q[k*PROBE_WIDTH +: PROBE_WIDTH];
            end
        end
    end

    always_comb begin
        case (mode_q)
            M_EQ:     match = ((cur_ch ^ value_q) & mask_q) == '0;
            M_NEQ:    match = ((cur_ch ^ value_q) & mask_q) != '0;
            M_CHANGE: match = prev_valid && (((cur_ch ^ prev_ch) & mask_q) != '0);
            default:  match = 1'b1;
        endcase
    end

    assign hit       = sample && !start && (state == S_ARMED) && match;
    assign trig_next = hit ? wr_addr : trig_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d = state;
        if (start) begin
            if (PRE_TRIGGER == 0 || (sample && PRE_TRIGGER == 1)) state_d = S_ARMED;
            else                                                   state_d = S_PRE;
        end else begin
            case (state)
                S_PRE:     if (sample && (int'(fill) + 1 == PRE_TRIGGER)) state_d = S_ARMED;
                S_ARMED:   if (hit) state_d = (POST_N == 0) ? S_READOUT : S_POST;
                S_POST:    if (sample && post == AW'(1)) state_d = S_READOUT;
                S_READOUT: if (end_beat) state_d = S_IDLE;
                default:   state_d = state;
            endcase
        end
    end

    // Readout pipeline: RAM read register (s1) feeding the output register.
    assign entering = (state_d == S_READOUT) && (state != S_READOUT);
    assign out_load = s1_valid && (!rd.rd_valid || rd.rd_ready);
    assign issue    = (state == S_READOUT) && (issue_cnt != BEATS) && (!s1_valid || out_load);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            fill        <= '0;
            post        <= '0;
            trig_ptr    <= '0;
            rd_ptr      <= '0;
            issue_cnt   <= '0;
            chan_q      <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            mode_q      <= M_EQ;
            prev_q      <= '0;
            prev_valid  <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_last  <= 1'b0;
        end else begin
            if (start) begin
                chan_q     <= trig_channel;
                value_q    <= trig_value;
                mask_q     <= trig_mask;
                mode_q     <= mode_t'(trig_mode);
                wr_ptr     <= '0;
                fill       <= '0;
                prev_valid <= 1'b0;
                triggered  <= 1'b0;
                done       <= 1'b0;
            end
            if (sample) begin
                wr_ptr     <= wr_addr + 1'b1;
                prev_q     <= probe_data;
                // With no pre-trigger history the first armed sample has nothing to compare to.
                prev_valid <= (PRE_TRIGGER != 0) || !start;
                if (start || state == S_PRE) fill <= (start ? '0 : fill) + 1'b1;
                if (!start && state == S_POST) post <= post - 1'b1;
            end
            if (hit) begin
                triggered <= 1'b1;
                trig_ptr  <= wr_addr;
                post      <= POST_INIT;
            end
            if (end_beat) done <= 1'b1;

            if (entering) begin
                rd_ptr    <= trig_next - PRE_OFS;
                issue_cnt <= '0;
                s1_valid  <= 1'b0;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                issue_cnt <= issue_cnt + 1'b1;
                s1_valid  <= 1'b1;
                s1_last   <= (issue_cnt == LAST_CNT);
            end else if (out_load) begin
                s1_valid  <= 1'b0;
            end

            if (out_load) begin
                rd.rd_valid <= 1'b1;
                rd.rd_data  <= ram_q;
                rd.rd_last  <= s1_last;
            end else if (rd.rd_valid && rd.rd_ready) begin
                rd.rd_valid <= 1'b0;
                rd.rd_last  <= 1'b0;
            end
        end
    end

    // NOTE: the buffer RAM and its read register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (sample) mem[wr_addr] <= probe_data;
        if (issue)  ram_q        <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_trace_capture.sv
// Randomised bench for trace_capture: a sample-history model predicts each captured
// window into a scoreboard queue that a negedge monitor drains as beats appear.
module tb_trace_capture;
    localparam int NP     = 2;
    localparam int PW     = 8;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int DW     = NP * PW;
    localparam int POST_N = DEPTH - PRE - 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] probe_data = '0;
    logic          probe_valid = 1'b0;
    logic          arm = 1'b0;
    logic [0:0]    trig_channel = '0;
    logic [PW-1:0] trig_value = '0;
    logic [PW-1:0] trig_mask = '0;
    logic [1:0]    trig_mode = '0;
    logic          busy, triggered, done;

    trace_capture_if #(.DATA_W(DW)) rd_if ();

    trace_capture #(
        .NUM_PROBES (NP),
        .PROBE_WIDTH(PW),
        .DEPTH      (DEPTH),
        .PRE_TRIGGER(PRE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .probe_data  (probe_data),
        .probe_valid (probe_valid),
        .arm         (arm),
        .trig_channel(trig_channel),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .trig_mode   (trig_mode),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done),
        .rd          (rd_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the capture is the list of samples since arm.
    logic [DW-1:0] hist[$];
    beat_t         exp_q[$];
    int            m_hit = -1;
    bit            m_active = 0, m_reading = 0, m_trig = 0;
    logic [1:0]    m_mode;
    int            m_chan;
    logic [PW-1:0] m_val, m_mask;
    int            cap_beats = 0;
    logic [DW-1:0] first_beat = '0;

    function automatic logic [PW-1:0] chan_of(input logic [DW-1:0] d, input int c);
        return d[c*PW +: PW];
    endfunction

    task automatic model_step(input logic a, input logic v, input logic [DW-1:0] d);
        int i;
        logic [PW-1:0] cur;
        bit h;
        if (a && !m_reading) begin
            m_active  = 1;
            hist.delete();
            m_hit     = -1;
            m_trig    = 0;
            cap_beats = 0;
            m_mode    = trig_mode;
            m_chan    = (int'(trig_channel) < NP) ? int'(trig_channel) : 0;
            m_val     = trig_value;
            m_mask    = trig_mask;
        end
        if (m_active && v) begin
            hist.push_back(d);
            i = hist.size() - 1;
            if (m_hit < 0 && i >= PRE) begin
                cur = chan_of(d, m_chan);
                case (m_mode)
                    2'd0:    h = (cur & m_mask) == (m_val & m_mask);
                    2'd1:    h = (cur & m_mask) != (m_val & m_mask);
                    2'd2:    h = (i > 0) && ((cur & m_mask) != (chan_of(hist[i-1], m_chan) & m_mask));
                    default: h = (i == PRE);
                endcase
                if (h) begin
                    m_hit  = i;
                    m_trig = 1;
                end
            end
            if (m_hit >= 0 && i == m_hit + POST_N) begin
                for (int j = 0; j < DEPTH; j++)
                    exp_q.push_back('{data: hist[m_hit - PRE + j], last: (j == DEPTH - 1)});
                m_active  = 0;
                m_reading = 1;
            end
        end
    endtask

    // Monitor: a beat is presented at negedge and transfers on the next posedge if ready.
    always @(negedge clk) begin
        beat_t e;
        if (reset_n && rd_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("beat_expected", 32'(rd_if.rd_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q[0];
                check("beat_data", 32'(rd_if.rd_data), 32'(e.data));
                check("beat_last", 32'(rd_if.rd_last), 32'(e.last));
                if (rd_if.rd_ready) begin
                    if (cap_beats == 0) first_beat = rd_if.rd_data;
                    void'(exp_q.pop_front());
                    cap_beats++;
                    if (e.last) m_reading = 0;
                end
            end
        end
    end

    // gen: 0 ch0 counts samples, 1 ch1 steps to 1 at sample 10, 2 random
    // rdy: 0 always, 1 pattern 1,0,0,1, 2 random;  vld: 0 always, 1 low every 3rd, 2 random
    // special: 0 none, 1 re-arm in POST, 2 arm during READOUT, 3 reset during READOUT
    task automatic run_capture(input logic [1:0] mode, input logic ch, input logic [7:0] val,
                               input logic [7:0] mask, input int gen, input int rdy,
                               input int vld, input int special);
        int cyc = 0, smp = 0;
        bit got_done = 0, fired = 0, chk_tr = 0, chk_rst = 0;
        logic a, v;
        logic [DW-1:0] d;
        trig_mode    = mode;
        trig_channel = ch;
        trig_value   = val;
        trig_mask    = mask;
        forever begin
            @(posedge clk);
            #1;
            if (chk_rst) begin
                check("reset_rd_valid", 32'(rd_if.rd_valid), 0);
                check("reset_busy", 32'(busy), 0);
                check("reset_done", 32'(done), 0);
                reset_n = 1'b1;
                break;
            end
            if (chk_tr) begin
                check("rearm_clears_triggered", 32'(triggered), 0);
                chk_tr = 0;
            end
            if (cyc > 0 && done) begin
                got_done = 1;
                break;
            end
            if (cyc > 800 || (cyc > 150 && m_hit < 0 && !m_reading)) break;

            a = (cyc == 0);
            case (vld)
                0:       v = 1'b1;
                1:       v = (cyc % 3) != 2;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            case (gen)
                0:       d = {8'($urandom), 8'(smp)};
                1:       d = {(smp >= 10) ? 8'h01 : 8'h00, 8'($urandom)};
                default: d = 16'($urandom);
            endcase
            case (rdy)
                0:       rd_if.rd_ready = 1'b1;
                1:       rd_if.rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_if.rd_ready = 1'($urandom);
            endcase
            if (special == 1 && !fired && m_active && m_hit >= 0 && hist.size() == m_hit + 4) begin
                a = 1'b1;
                fired = 1;
                chk_tr = 1;
                trig_mode = 2'd3;
            end
            if (special == 2 && !fired && m_reading && cap_beats == 3) begin
                a = 1'b1;
                fired = 1;
                trig_mode = 2'd3;
            end
            arm = a;
            probe_valid = v;
            probe_data = d;
            if (special == 3 && !fired && m_reading && cap_beats == 5) begin
                fired = 1;
                chk_rst = 1;
                reset_n = 1'b0;
                arm = 1'b0;
                probe_valid = 1'b0;
                rd_if.rd_ready = 1'b0;
                exp_q.delete();
                m_reading = 0;
                m_active = 0;
            end else begin
                model_step(arm, probe_valid, probe_data);
            end
            if (v) smp++;
            cyc++;
        end
        arm = 1'b0;
        if (special == 3) return;
        if (got_done) begin
            check("done_set", 32'(done), 1);
            check("busy_after_done", 32'(busy), 0);
            check("triggered_flag", 32'(triggered), 32'(m_trig));
            check("all_beats_seen", 32'(exp_q.size()), 0);
            check("rd_valid_idle", 32'(rd_if.rd_valid), 0);
        end else if (m_hit < 0 && !m_reading) begin
            check("no_trigger_flag", 32'(triggered), 0);
            check("no_trigger_busy", 32'(busy), 1);
        end else begin
            check("capture_timeout_done", 32'(done), 1);
        end
    endtask

    initial begin
        rd_if.rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_valid", 32'(rd_if.rd_valid), 0);
        check("rst_rd_last", 32'(rd_if.rd_last), 0);
        check("rst_rd_data", 32'(rd_if.rd_data), 0);
        reset_n = 1'b1;

        // Counting ch0, eq 0x20: window 0x1C..0x2B.
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 0, 0, 0);
        check("t1_first_beat", 32'(first_beat[7:0]), 32'h1C);
        check("t1_rd_data_held", 32'(rd_if.rd_data[7:0]), 32'h2B);

        // ch1 steps 0 -> 1 at sample 10, change mode, mask 0x01.
        run_capture(2'd2, 1'b1, 8'h00, 8'h01, 1, 0, 0, 0);
        check("t2_triggered", 32'(triggered), 1);
        check("t2_first_beat_ch1", 32'(first_beat[15:8]), 0);

        // Same as first run with stalls and gaps in probe_valid.
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 1, 1, 0);
        check("t3_first_beat", 32'(first_beat[7:0]), 32'h1C);
        check("t3_rd_data_held", 32'(rd_if.rd_data[7:0]), 32'h2B);

        // Immediate mode from ch0 = 0x00: window 0x00..0x0F.
        run_capture(2'd3, 1'b0, 8'h00, 8'h00, 0, 0, 0, 0);
        check("t4_first_beat", 32'(first_beat[7:0]), 32'h00);
        check("t4_rd_data_held", 32'(rd_if.rd_data[7:0]), 32'h0F);

        // Re-arm in POST, then arm during READOUT.
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 0, 0, 1);
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 1, 0, 2);
        check("t5_readout_kept_trigger", 32'(first_beat[7:0]), 32'h1C);

        // Reset mid-READOUT, then a clean capture.
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 0, 0, 3);
        run_capture(2'd0, 1'b0, 8'h20, 8'hFF, 0, 0, 0, 0);
        check("t6_first_beat", 32'(first_beat[7:0]), 32'h1C);

        // Randomised captures: all modes, both channels, random masks and handshakes.
        for (int r = 0; r < 8; r++) begin
            logic [1:0] md;
            logic [7:0] mk;
            md = 2'($urandom_range(0, 3));
            mk = (md == 2'd0) ? 8'($urandom & $urandom & $urandom) : 8'($urandom | 1);
            run_capture(md, 1'($urandom), 8'($urandom), mk, 2, 2, 2, 0);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end
endmodule
